// File: rtl/cpu_sequencer_if.sv
// Instruction-memory and datapath-control bundle between the sequencer and the
// rest of the 8-bit, 4-register CPU.
interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic [7:0]          instruction;
  logic [PC_WIDTH-1:0] Read_Address;
  logic [1:0]          rs;
  logic [1:0]          rt;
  logic [1:0]          wr_reg;
  logic [7:0]          imm;
  logic                ALUSrc;
  logic                MemRead;
  logic                MemWrite;
  logic                MemtoReg;
  logic                RegWrite;

  modport master (
    input  instruction,
    output Read_Address, rs, rt, wr_reg, imm,
    output ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite
  );

  modport slave (
    output instruction,
    input  Read_Address, rs, rt, wr_reg, imm,
    input  ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns the PC, latches each instruction and walks
// it through FETCH/DECODE/EXEC/MEM/WB while driving the datapath strobes.
// Strobes are registered from the next state and next IR, so they present the
// same cycle-by-cycle behaviour as a decode of the state register while coming
// straight out of flops (and clearing asynchronously on reset).
module cpu_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int PROG_LEN = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  cpu_sequencer_if.master   bus,
  output logic              halted,
  output logic [7:0]        retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } strobe_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam logic [31:0]         PROG_LEN_C = 32'(PROG_LEN);
  localparam logic [PC_WIDTH-1:0] RESET_PC_C = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE_C   = PC_WIDTH'(1);

  // Strobe pattern for a given state and latched instruction.
  function automatic strobe_t decode_strobes(input state_t st, input logic [7:0] ir);
    strobe_t s;
    s = strobe_t'(5'b00000);
    case (st)
      ST_EXEC: begin
        s.alu_src = (ir[7:6] == OP_LW) || (ir[7:6] == OP_SW);
      end
      ST_MEM: begin
        s.alu_src   = 1'b1;
        s.mem_read  = (ir[7:6] == OP_LW);
        s.mem_write = (ir[7:6] == OP_SW);
      end
      ST_WB: begin
        s.reg_write = 1'b1;
        if (ir[7:6] == OP_LW) begin
          s.alu_src    = 1'b1;
          s.mem_read   = 1'b1;
          s.mem_to_reg = 1'b1;
        end else begin
          s.alu_src    = 1'b0;
          s.mem_read   = 1'b0;
          s.mem_to_reg = 1'b0;
        end
      end
      default: begin
        s = strobe_t'(5'b00000);
      end
    endcase
    return s;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_nxt_s;
  logic [7:0]          ir_r;
  logic [7:0]          ir_nxt_s;
  logic [7:0]          retired_r;
  logic                retire_s;
  strobe_t             strobe_r;
  logic                halted_r;
  logic [31:0]         pc_ext_s;
  logic [PC_WIDTH-1:0] jump_ofs_s;
  state_t              boundary_s;

  assign pc_ext_s   = 32'(pc_r);
  // Jump offset is IR[5:0] sign-extended; PC already points at addr+1.
  assign jump_ofs_s = {{(PC_WIDTH-6){ir_r[5]}}, ir_r[5:0]};
  assign boundary_s = run ? ST_FETCH : ST_IDLE;

  // Next-state, next-PC, next-IR and retire decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    retire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (pc_ext_s >= PROG_LEN_C) begin
          state_nxt_s = ST_HALT;
        end else begin
          ir_nxt_s    = bus.instruction;
          pc_nxt_s    = pc_r + PC_ONE_C;
          state_nxt_s = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (ir_r[7:6] == OP_J) begin
          pc_nxt_s    = pc_r + jump_ofs_s;
          retire_s    = 1'b1;
          state_nxt_s = boundary_s;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ir_r[7:6] == OP_ADD) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_MEM;
        end
      end
      ST_MEM: begin
        if (ir_r[7:6] == OP_LW) begin
          state_nxt_s = ST_WB;
        end else begin
          retire_s    = 1'b1;
          state_nxt_s = boundary_s;
        end
      end
      ST_WB: begin
        retire_s    = 1'b1;
        state_nxt_s = boundary_s;
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, PC, IR and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC_C;
      ir_r      <= 8'h00;
      retired_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
      if (retire_s) begin
        retired_r <= retired_r + 8'd1;
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Registered strobes and halt flag, aligned with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_r <= strobe_t'(5'b00000);
      halted_r <= 1'b0;
    end else begin
      strobe_r <= decode_strobes(state_nxt_s, ir_nxt_s);
      halted_r <= (state_nxt_s == ST_HALT);
    end
  end

  assign bus.Read_Address = pc_r;
  assign bus.rs           = ir_r[5:4];
  assign bus.rt           = ir_r[3:2];
  assign bus.wr_reg       = (ir_r[7:6] == OP_LW) ? ir_r[3:2] : ir_r[1:0];
  assign bus.imm          = {{6{ir_r[1]}}, ir_r[1:0]};
  assign bus.ALUSrc       = strobe_r.alu_src;
  assign bus.MemRead      = strobe_r.mem_read;
  assign bus.MemWrite     = strobe_r.mem_write;
  assign bus.MemtoReg     = strobe_r.mem_to_reg;
  assign bus.RegWrite     = strobe_r.reg_write;
  assign halted           = halted_r;
  assign retired          = retired_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset abort, a short program with a jump,
// strobe timing, run-drop at an instruction boundary, a jump self-loop with
// retire-counter wrap, and HALT stickiness.
module tb_cpu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       halted;
  logic [7:0] retired;
  logic [7:0] mem [256];
  logic [4:0] strb;
  int         total = 0;
  int         bad   = 0;

  cpu_sequencer_if #(.PC_WIDTH(8)) bus ();

  assign bus.instruction = mem[bus.Read_Address];
  // {ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite}
  assign strb = {bus.ALUSrc, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite};

  cpu_sequencer #(.PC_WIDTH(8), .PROG_LEN(6), .RESET_PC(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .bus     (bus),
    .halted  (halted),
    .retired (retired)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Hold reset for two cycles, release at a falling edge with run low.
  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected values after each rising edge of the program run (edge 1..22).
  int exp_pc   [22] = '{0,1,1,1,1,1,2,3,4,4,4,4,5,5,5,5,5,6,6,6,6,6};
  int exp_ret  [22] = '{0,0,0,0,0,1,1,2,2,2,2,3,3,3,3,3,4,4,4,4,5,5};
  int exp_strb [22] = '{'h00,'h00,'h10,'h18,'h1B,'h00,'h00,'h00,'h00,'h10,'h14,
                        'h00,'h00,'h10,'h18,'h1B,'h00,'h00,'h00,'h01,'h00,'h00};
  int exp_wr   [22] = '{0,0,0,0,2,0,0,0,0,0,0,0,0,0,0,3,0,0,0,0,0,0};

  initial begin
    int   seen;
    int   cyc;
    int   k;

    // ---------------- 1. reset, including abort in MEM of sw ----------------
    clear_mem();
    mem[0] = 8'hA9;
    rst_n  = 1'b0;
    run    = 1'b0;
    @(negedge clk);
    chk("rst_pc", 32'(bus.Read_Address), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_strobes", 32'(strb), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    seen  = 0;
    cyc   = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.MemWrite) seen = 1;
    end
    chk("sw_memwrite_seen", 32'(seen), 32'd1);
    chk("sw_mem_edge", 32'(cyc), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("abort_strobes", 32'(strb), 32'd0);
    chk("abort_pc", 32'(bus.Read_Address), 32'd0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pc", 32'(bus.Read_Address), 32'd0);
    chk("idle_retired", 32'(retired), 32'd0);
    chk("idle_strobes", 32'(strb), 32'd0);
    chk("idle_halted", 32'(halted), 32'd0);

    // ---------------- 2/3. program run with jump, strobes, halt ----------------
    clear_mem();
    mem[0] = 8'h49;
    mem[1] = 8'hC1;
    mem[2] = 8'h18;
    mem[3] = 8'hA9;
    mem[4] = 8'h7D;
    mem[5] = 8'h1C;
    do_reset();
    run = 1'b1;
    for (int e = 0; e < 22; e++) begin
      @(negedge clk);
      chk($sformatf("prog_pc_e%0d", e + 1), 32'(bus.Read_Address), 32'(exp_pc[e]));
      chk($sformatf("prog_ret_e%0d", e + 1), 32'(retired), 32'(exp_ret[e]));
      chk($sformatf("prog_strb_e%0d", e + 1), 32'(strb), 32'(exp_strb[e]));
      chk($sformatf("prog_halt_e%0d", e + 1), 32'(halted), (e == 21) ? 32'd1 : 32'd0);
      if (exp_strb[e][0]) begin
        chk($sformatf("prog_wr_e%0d", e + 1), 32'(bus.wr_reg), 32'(exp_wr[e]));
      end
    end

    // ---------------- 6. HALT is sticky regardless of run ----------------
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_strobes", 32'(strb), 32'd0);
      chk("halt_pc", 32'(bus.Read_Address), 32'd6);
      chk("halt_retired", 32'(retired), 32'd5);
    end

    // ---------------- 4. run dropped during EXEC of add ----------------
    clear_mem();
    mem[0] = 8'h18;
    mem[1] = 8'h1E;
    do_reset();
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("drop_exec_strb", 32'(strb), 32'd0);
    run = 1'b0;
    @(negedge clk);
    chk("drop_wb_strb", 32'(strb), 32'h01);
    chk("drop_wb_wr", 32'(bus.wr_reg), 32'd0);
    @(negedge clk);
    chk("drop_retired", 32'(retired), 32'd1);
    chk("drop_idle_strb", 32'(strb), 32'd0);
    repeat (3) @(negedge clk);
    chk("drop_idle_pc", 32'(bus.Read_Address), 32'd1);
    chk("drop_idle_ret", 32'(retired), 32'd1);
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("resume_pc", 32'(bus.Read_Address), 32'd2);
    chk("resume_wr", 32'(bus.wr_reg), 32'd2);
    chk("resume_rs", 32'(bus.rs), 32'd1);
    repeat (2) @(negedge clk);
    chk("resume_wb_strb", 32'(strb), 32'h01);
    @(negedge clk);
    chk("resume_retired", 32'(retired), 32'd2);

    // ---------------- 5. jump self-loop and retire wrap ----------------
    clear_mem();
    mem[0] = 8'hFF;
    do_reset();
    run = 1'b1;
    for (int e = 1; e <= 515; e++) begin
      @(negedge clk);
      if ((e % 2) == 1) begin
        k = (e - 1) / 2;
        if (k == 1 || k == 2 || k == 255 || k == 256 || k == 257) begin
          chk($sformatf("loop_pc_k%0d", k), 32'(bus.Read_Address), 32'd0);
          chk($sformatf("loop_ret_k%0d", k), 32'(retired), 32'(k % 256));
        end
      end
    end
    chk("loop_halted", 32'(halted), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
